ps2_tx_ctrl: RTL

Host-to-device transmit sequencer for the PS/2 port. It sends one command byte, such as 0xED (set LEDs) or 0xF4 (enable), to the keyboard: it inhibits the bus, issues request-to-send, shifts out data, parity and stop on device-generated clocks, then checks the device ACK. It sits beside the PS/2 receive path, drives the open-drain enables of the shared ps2_clk/ps2_dat pads, and raises rx_inhibit_o so the receiver ignores the host-driven frame.

---
 rtl/ps2_tx_pkg.sv | 20 ++
 rtl/ps2_sync_fe.sv | 36 +++
 rtl/ps2_tx_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: shared types and constants for the PS/2 host transmit path.
package ps2_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INHIBIT,
        SHIFT,
        WAIT_IDLE
    } state_t;

    localparam logic [3:0] FE_DATA_LAST = 4'd8;
    localparam logic [3:0] FE_PAR       = 4'd9;
    localparam logic [3:0] FE_STOP      = 4'd10;
    localparam logic [3:0] FE_ACK       = 4'd11;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_fe.sv
// ps2_sync_fe: pad synchroniser for ps2 clock/data plus a one-cycle
// pulse on each falling edge of the synchronised clock.
module ps2_sync_fe #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_sync,
    output logic dat_sync,
    output logic fe
);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] dat_sr;
    logic                   clk_prev;

    // Reset to the released-bus level so no edge is seen out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sr   <= '1;
            dat_sr   <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= (clk_sr << 1) | SYNC_STAGES'(ps2_clk);
            dat_sr   <= (dat_sr << 1) | SYNC_STAGES'(ps2_dat);
            clk_prev <= clk_sync;
        end
    end

    assign clk_sync = clk_sr[SYNC_STAGES-1];
    assign dat_sync = dat_sr[SYNC_STAGES-1];
    assign fe       = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_tx_ctrl.sv
// ps2_tx_ctrl: host-to-device PS/2 command byte transmitter.
// Build option PS2_TX_RETRY_EN: resend once after a NAK or timeout.
module ps2_tx_ctrl
    import ps2_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    input  logic       abort_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic       rx_inhibit_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       timeout_o
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]    idx, idx_nx, fe_num;
    logic [7:0]    data;
    logic          parity;
    logic          clk_oe, clk_oe_nx;
    logic          dat_oe, dat_oe_nx;
    logic          done, done_nx;
    logic          ack_err, ack_err_nx;
    logic          timeout, timeout_nx;
    logic          take, ack_fail, to_fail;
    logic          clk_sync, dat_sync, fe;
`ifdef PS2_TX_RETRY_EN
    logic          retry, retry_nx;
`endif

    ps2_sync_fe #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk_i),
        .rst     (rst_i),
        .ps2_clk (ps2_clk_i),
        .ps2_dat (ps2_dat_i),
        .clk_sync(clk_sync),
        .dat_sync(dat_sync),
        .fe      (fe)
    );

    assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + CW'(1);
    assign fe_num  = idx + 4'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            data    <= '0;
            parity  <= 1'b0;
            clk_oe  <= 1'b0;
            dat_oe  <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            clk_oe  <= clk_oe_nx;
            dat_oe  <= dat_oe_nx;
            done    <= done_nx;
            ack_err <= ack_err_nx;
            timeout <= timeout_nx;
`ifdef PS2_TX_RETRY_EN
            retry   <= retry_nx;
`endif
            if (take) begin
                data   <= tx_data_i;
                parity <= odd_parity(tx_data_i);
            end
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt_inc;
        idx_nx     = idx;
        clk_oe_nx  = clk_oe;
        dat_oe_nx  = dat_oe;
        done_nx    = 1'b0;
        ack_err_nx = 1'b0;
        timeout_nx = 1'b0;
        take       = 1'b0;
        ack_fail   = 1'b0;
        to_fail    = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_nx   = retry;
`endif
        unique case (state)
            IDLE: begin
                if (tx_valid_i) begin
                    take      = 1'b1;
                    state_nx  = INHIBIT;
                    cnt_nx    = '0;
                    idx_nx    = '0;
                    clk_oe_nx = 1'b1;
                    dat_oe_nx = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    retry_nx  = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                // Release clock and drive the start bit together (RTS).
                if (cnt == INH_LAST) begin
                    state_nx  = SHIFT;
                    cnt_nx    = '0;
                    idx_nx    = '0;
                    clk_oe_nx = 1'b0;
                    dat_oe_nx = 1'b1;
                end
            end
            SHIFT: begin
                if (fe) begin
                    cnt_nx = '0;
                    idx_nx = fe_num;
                    if (fe_num <= FE_DATA_LAST) begin
                        dat_oe_nx = ~data[idx[2:0]];
                    end else if (fe_num == FE_PAR) begin
                        dat_oe_nx = ~parity;
                    end else if (fe_num == FE_STOP) begin
                        dat_oe_nx = 1'b0;
                    end else if (fe_num == FE_ACK) begin
                        if (dat_sync) begin
                            ack_fail = 1'b1;
                        end else begin
                            state_nx = WAIT_IDLE;
                        end
                    end
                end else if (cnt_inc == TO_LIM) begin
                    to_fail = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (fe) begin
                    cnt_nx = '0;
                end else if (cnt_inc == TO_LIM) begin
                    to_fail = 1'b1;
                end
            end
        endcase

        if (ack_fail || to_fail) begin
            state_nx  = IDLE;
            clk_oe_nx = 1'b0;
            dat_oe_nx = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (!retry) begin
                retry_nx  = 1'b1;
                state_nx  = INHIBIT;
                cnt_nx    = '0;
                idx_nx    = '0;
                clk_oe_nx = 1'b1;
            end else begin
                ack_err_nx = ack_fail;
                timeout_nx = to_fail;
            end
`else
            ack_err_nx = ack_fail;
            timeout_nx = to_fail;
`endif
        end

        // Abort wins over any same-cycle edge, timeout or completion.
        if (abort_i && state != IDLE) begin
            state_nx   = IDLE;
            clk_oe_nx  = 1'b0;
            dat_oe_nx  = 1'b0;
            done_nx    = 1'b0;
            ack_err_nx = 1'b0;
            timeout_nx = 1'b0;
        end
    end

    always_comb begin
        tx_ready_o   = (state == IDLE);
        busy_o       = (state != IDLE);
        rx_inhibit_o = (state != IDLE);
        ps2_clk_oe_o = clk_oe;
        ps2_dat_oe_o = dat_oe;
        done_o       = done;
        ack_err_o    = ack_err;
        timeout_o    = timeout;
    end

endmodule
